// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs instruction requests into 16-bit program words and writes
// them to sequential program-memory addresses. Define READBACK_VERIFY_EN to verify each write.
module instr_encoder_loader #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1:0]    in_kind_i,
    input  logic [4:0]    in_op_i,
    input  logic [3:0]    in_src_i,
    input  logic [3:0]    in_dst_i,
    input  logic [3:0]    in_flags_i,
    input  logic [9:0]    in_offset_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [15:0]   mem_wdata_o,
    output logic          mem_we_o,
`ifdef READBACK_VERIFY_EN
    input  logic [15:0]   mem_rdata_i,
`endif
    output logic          busy_o,
    output logic [AW:0]   word_count_o,
    output logic          err_valid_o,
    output logic [1:0]    err_code_o
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] AddrOne  = AW'(1);
    localparam logic [AW:0]   CountOne = (AW + 1)'(1);

    localparam logic [1:0] KindDouble = 2'd0;
    localparam logic [1:0] KindSingle = 2'd1;
    localparam logic [1:0] KindJump   = 2'd2;

    localparam logic [1:0] ErrIllegal  = 2'd1;
    localparam logic [1:0] ErrFull     = 2'd2;
    localparam logic [1:0] ErrReadback = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StEnc,
        StWr,
        StVrd,
        StVcmp
    } state_e;

    state_e          state_q;
    logic            armed_q;
    logic            full_q;
    logic [AW-1:0]   addr_q;
    logic [AW:0]     count_q;
    logic [15:0]     word_q;
    logic [AW-1:0]   mem_addr_q;
    logic [15:0]     mem_wdata_q;
    logic            mem_we_q;
    logic            err_valid_q;
    logic [1:0]      err_code_q;

    logic            accept;
    logic [15:0]     enc_word;
    logic            enc_illegal;
    logic [5:0]      sg;
    logic [3:0]      single_reg;

    assign in_ready_o = (state_q == StIdle) && armed_q && !start_i;
    assign accept     = in_valid_i && in_ready_o;

    // Encode straight from the request so the word and legality are registered on accept.
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        sg          = '0;
        single_reg  = in_dst_i;
        case (in_kind_i)
            KindDouble: begin
                enc_illegal = (in_op_i > 5'd11);
                enc_word    = {in_op_i[3:0] + 4'd4, in_src_i, in_flags_i, in_dst_i};
            end
            KindSingle: begin
                case (in_op_i)
                    5'h10:   sg = 6'd0;
                    5'h11:   sg = 6'd1;
                    5'h12:   sg = 6'd2;
                    5'h13:   sg = 6'd4;
                    5'h14:   sg = 6'd5;
                    5'h15:   sg = 6'd6;
                    5'h16:   sg = 6'd8;
                    5'h17:   sg = 6'd9;
                    5'h18:   sg = 6'd10;
                    5'h19:   sg = 6'd12;
                    default: enc_illegal = 1'b1;
                endcase
                // PUSH and PUSH.B take their operand from the source field.
                if (in_op_i == 5'h16 || in_op_i == 5'h17) begin
                    single_reg = in_src_i;
                end
                enc_word = {4'h1, sg, in_flags_i[1:0], single_reg};
            end
            KindJump: begin
                enc_word = {3'b001, in_op_i[2], in_op_i[1:0], in_offset_i};
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            full_q      <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else begin
            mem_we_q    <= 1'b0;
            err_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        addr_q  <= base_addr_i;
                        count_q <= '0;
                        full_q  <= 1'b0;
                        armed_q <= 1'b1;
                    end else if (accept) begin
                        word_q  <= enc_word;
                        state_q <= StEnc;
                        if (enc_illegal) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ErrIllegal;
                        end else if (full_q) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ErrFull;
                        end
                    end
                end
                StEnc: begin
                    if (err_valid_q) begin
                        state_q <= StIdle;
                    end else begin
                        state_q     <= StWr;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= word_q;
                    end
                end
                StWr: begin
                    count_q <= count_q + CountOne;
`ifdef READBACK_VERIFY_EN
                    state_q <= StVrd;
`else
                    state_q <= StIdle;
                    if (addr_q == LastAddr) begin
                        full_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + AddrOne;
                    end
`endif
                end
`ifdef READBACK_VERIFY_EN
                StVrd: begin
                    state_q <= StVcmp;
                end
                StVcmp: begin
                    // Address advances only now so the readback targets the written word.
                    state_q <= StIdle;
                    if (addr_q == LastAddr) begin
                        full_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + AddrOne;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef READBACK_VERIFY_EN
    logic rb_mismatch;
    assign rb_mismatch = (state_q == StVcmp) && (mem_rdata_i != mem_wdata_q);
    assign err_valid_o = err_valid_q || rb_mismatch;
    assign err_code_o  = rb_mismatch ? ErrReadback : err_code_q;
`else
    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;
`endif

    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;
    assign busy_o       = (state_q != StIdle);
    assign word_count_o = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: expected writes/errors are queued at request time
// and matched (content and cycle) against the memory write port and error channel.
module tb_instr_encoder_loader;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [4:0]    in_op = '0;
    logic [3:0]    in_src = '0;
    logic [3:0]    in_dst = '0;
    logic [3:0]    in_flags = '0;
    logic [9:0]    in_offset = '0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_we;
    logic          busy;
    logic [AW:0]   word_count;
    logic          err_valid;
    logic [1:0]    err_code;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [7:0]  addr;
        logic [15:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int unsigned cyc      = 0;
    int unsigned we_cnt   = 0;
    logic [7:0]  exp_addr = '0;
    bit          exp_full = 1'b0;

`ifdef READBACK_VERIFY_EN
    logic [15:0] mem_model [DEPTH];
    logic [15:0] mem_rdata = '0;
    bit          corrupt_mem = 1'b0;

    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= corrupt_mem ? (mem_wdata ^ 16'h0001) : mem_wdata;
        mem_rdata <= mem_model[mem_addr];
    end
`endif

    instr_encoder_loader #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_kind_i    (in_kind),
        .in_op_i      (in_op),
        .in_src_i     (in_src),
        .in_dst_i     (in_dst),
        .in_flags_i   (in_flags),
        .in_offset_i  (in_offset),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
`ifdef READBACK_VERIFY_EN
        .mem_rdata_i  (mem_rdata),
`endif
        .busy_o       (busy),
        .word_count_o (word_count),
        .err_valid_o  (err_valid),
        .err_code_o   (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every write or error pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) we_cnt++;
        if (mem_we || err_valid) begin
            check_val("we_err_exclusive", 32'(mem_we & err_valid), 32'd0);
            check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("out_is_err", 32'(err_valid), 32'(e.is_err));
                check_val("out_cycle", cyc, e.cyc);
                if (e.is_err) begin
                    check_val("err_code", 32'(err_code), 32'(e.code));
                end else begin
                    check_val("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check_val("mem_wdata", 32'(mem_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic push_exp(input bit is_err, input logic [1:0] code, input logic [7:0] addr,
                            input logic [15:0] data, input int unsigned when);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.addr   = addr;
        e.data   = data;
        e.cyc    = when;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        in_valid  = 1'b1;
        #1 check_val("rdy_during_start", 32'(in_ready), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        exp_addr = base;
        exp_full = 1'b0;
        check_val("count_after_start", 32'(word_count), 32'd0);
    endtask

    task automatic send(input logic [1:0] kind, input logic [4:0] op, input logic [3:0] src,
                        input logic [3:0] dst, input logic [3:0] flags, input logic [9:0] off,
                        input bit illegal, input logic [15:0] word);
        bit rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = in_ready;
        end
        check_val("in_ready_wait", 32'(rdy), 32'd1);
        if (!rdy) return;
        in_kind   = kind;
        in_op     = op;
        in_src    = src;
        in_dst    = dst;
        in_flags  = flags;
        in_offset = off;
        in_valid  = 1'b1;
        if (illegal) begin
            push_exp(1'b1, 2'd1, '0, '0, cyc + 1);
        end else if (exp_full) begin
            push_exp(1'b1, 2'd2, '0, '0, cyc + 1);
        end else begin
            push_exp(1'b0, '0, exp_addr, word, cyc + 2);
`ifdef READBACK_VERIFY_EN
            if (corrupt_mem) push_exp(1'b1, 2'd3, '0, '0, cyc + 4);
`endif
            if (exp_addr == 8'(DEPTH - 1)) exp_full = 1'b1;
            else exp_addr = exp_addr + 8'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("busy_in_enc", 32'(busy), 32'd1);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned we_before;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_err_valid", 32'(err_valid), 32'd0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        check_val("rst_word_count", 32'(word_count), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("unarmed_ready", 32'(in_ready), 32'd0);
        end

        do_start(8'h10);
        send(2'd0, 5'd0, 4'd5, 4'd9, 4'd0, 10'h000, 1'b0, 16'h4509);
        settle();
        check_val("count_one", 32'(word_count), 32'd1);
        send(2'd2, 5'b00111, 4'd0, 4'd0, 4'd0, 10'h3FF, 1'b0, 16'h3FFF);
        send(2'd2, 5'b00000, 4'd0, 4'd0, 4'd0, 10'h005, 1'b0, 16'h2005);
        send(2'd1, 5'h13, 4'hA, 4'd4, 4'd0, 10'h000, 1'b0, 16'h1104);
        send(2'd1, 5'h16, 4'd7, 4'd2, 4'd0, 10'h000, 1'b0, 16'h1207);
        send(2'd0, 5'd12, 4'd1, 4'd1, 4'd1, 10'h000, 1'b1, 16'h0000);
        send(2'd3, 5'd0, 4'd1, 4'd1, 4'd1, 10'h000, 1'b1, 16'h0000);
        send(2'd1, 5'h1A, 4'd1, 4'd1, 4'd1, 10'h000, 1'b1, 16'h0000);
        send(2'd0, 5'd11, 4'd1, 4'd3, 4'd2, 10'h000, 1'b0, 16'hF123);
        send(2'd2, 5'b11010, 4'd0, 4'd0, 4'd0, 10'h2AA, 1'b0, 16'h2AAA);
        settle();
        check_val("count_seven", 32'(word_count), 32'd7);

        // Top-of-memory boundary: two writes fill it, the third is refused.
        do_start(8'hFE);
        send(2'd0, 5'd1, 4'd0, 4'd0, 4'd0, 10'h000, 1'b0, 16'h5000);
        send(2'd0, 5'd2, 4'd0, 4'd0, 4'd0, 10'h000, 1'b0, 16'h6000);
        send(2'd0, 5'd3, 4'd0, 4'd0, 4'd0, 10'h000, 1'b0, 16'h7000);
        settle();
        check_val("count_full", 32'(word_count), 32'd2);
        do_start(8'h20);
        send(2'd2, 5'b00100, 4'd0, 4'd0, 4'd0, 10'h001, 1'b0, 16'h3001);
        settle();
        check_val("count_restart", 32'(word_count), 32'd1);

`ifdef READBACK_VERIFY_EN
        corrupt_mem = 1'b1;
        send(2'd0, 5'd0, 4'd1, 4'd2, 4'd3, 10'h000, 1'b0, 16'h4123);
        settle();
        corrupt_mem = 1'b0;
        check_val("count_rb_err", 32'(word_count), 32'd2);
        send(2'd0, 5'd0, 4'd4, 4'd5, 4'd6, 10'h000, 1'b0, 16'h4465);
        settle();
`endif

        // Reset while the accepted word sits in ENC: the write must never happen.
        begin
            bit rdy = 1'b0;
            for (int i = 0; i < 20 && !rdy; i++) begin
                @(negedge clk);
                rdy = in_ready;
            end
            check_val("in_ready_wait", 32'(rdy), 32'd1);
            in_kind  = 2'd0;
            in_op    = 5'd0;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid  = 1'b0;
            we_before = we_cnt;
            rst       = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            check_val("rst_drop_we", we_cnt - we_before, 32'd0);
            check_val("rst_mid_busy", 32'(busy), 32'd0);
            check_val("rst_mid_count", 32'(word_count), 32'd0);
            repeat (3) begin
                @(negedge clk);
                check_val("rearm_ready", 32'(in_ready), 32'd0);
            end
        end
        do_start(8'h30);
        send(2'd1, 5'h10, 4'd0, 4'd3, 4'd1, 10'h000, 1'b0, 16'h1013);
        settle();
        check_val("count_after_rearm", 32'(word_count), 32'd1);
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
